// File: rtl/room_light_arbiter.sv
// room_light_arbiter: shares MAX_ON lamp slots among N_ROOMS occupancy requesters.
// Rooms are granted round-robin, one new grant per cycle. A lit room keeps its lamp
// for HOLD_CYC cycles after it goes vacant, then gives the slot back.
//
//  state | meaning
//  IDLE  | no lamp lit and no room requesting
//  RUN   | lamps lit or requests waiting, slots available or nothing blocked
//  FULL  | every slot in use while at least one room is still waiting
module room_light_arbiter #(
    parameter int N_ROOMS  = 8,
    parameter int MAX_ON   = 5,
    parameter int HOLD_CYC = 10,
    parameter int CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [N_ROOMS-1:0]           rooms,
    output logic [N_ROOMS-1:0]           lightson,
    output logic [N_ROOMS*CNT_W-1:0]     countdown,
    output logic [$clog2(N_ROOMS+1)-1:0] active_cnt,
    output logic [N_ROOMS-1:0]           pending,
    output logic                         full,
    output logic [1:0]                   state
);

    localparam int AW = $clog2(N_ROOMS + 1);
    localparam int PW = $clog2(N_ROOMS);
    localparam logic [AW-1:0]    MAX_C  = AW'(MAX_ON);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                   st;
    state_t                   st_nxt;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            gnt_idx;
    logic [PW-1:0]            scan_idx;
    logic                     found;
    logic                     do_grant;
    logic [N_ROOMS-1:0]       lit_nxt;
    logic [N_ROOMS*CNT_W-1:0] cd_nxt;
    logic [AW-1:0]            cnt_nxt;

    assign pending = rooms & ~lightson;
    assign state   = st;

    // Round-robin search: first pending room at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < N_ROOMS; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % N_ROOMS);
            if (!found && pending[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // A grant only looks at the pre-edge count, so a slot freed this edge is reusable next edge.
    assign do_grant = enable && found && (active_cnt < MAX_C);

    // Next lamp/timer values, their popcount, and the FSM state derived from them.
    always_comb begin
        lit_nxt = lightson;
        cd_nxt  = countdown;
        cnt_nxt = '0;
        for (int i = 0; i < N_ROOMS; i++) begin
            if (lightson[i]) begin
                if (rooms[i]) begin
                    cd_nxt[i*CNT_W +: CNT_W] = HOLD_C;
                end else if (countdown[i*CNT_W +: CNT_W] > CNT_W'(1)) begin
                    cd_nxt[i*CNT_W +: CNT_W] = countdown[i*CNT_W +: CNT_W] - CNT_W'(1);
                end else begin
                    cd_nxt[i*CNT_W +: CNT_W] = '0;
                    lit_nxt[i]               = 1'b0;
                end
            end else if (do_grant && (gnt_idx == PW'(i))) begin
                lit_nxt[i]               = 1'b1;
                cd_nxt[i*CNT_W +: CNT_W] = HOLD_C;
            end else begin
                cd_nxt[i*CNT_W +: CNT_W] = '0;
            end
        end
        for (int i = 0; i < N_ROOMS; i++) begin
            cnt_nxt = cnt_nxt + AW'(lit_nxt[i]);
        end
        if ((lit_nxt == '0) && (rooms == '0)) begin
            st_nxt = IDLE;
        end else if ((cnt_nxt == MAX_C) && ((rooms & ~lit_nxt) != '0)) begin
            st_nxt = FULL;
        end else begin
            st_nxt = RUN;
        end
    end

    // Register lamps, timers, count, pointer and FSM state together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lightson   <= '0;
            countdown  <= '0;
            active_cnt <= '0;
            rr_ptr     <= '0;
            st         <= IDLE;
            full       <= 1'b0;
        end else begin
            lightson   <= lit_nxt;
            countdown  <= cd_nxt;
            active_cnt <= cnt_nxt;
            st         <= st_nxt;
            full       <= (st_nxt == FULL);
            if (do_grant) begin
                rr_ptr <= (gnt_idx == PW'(N_ROOMS - 1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_room_light_arbiter.sv
// Bench for room_light_arbiter at default parameters: a vector table for the
// single-stepped scenarios plus hand-written multi-cycle sequences.
module tb_room_light_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  rooms = 8'h00;
    logic [7:0]  lightson;
    logic [31:0] countdown;
    logic [3:0]  active_cnt;
    logic [7:0]  pending;
    logic        full;
    logic [1:0]  state;

    int n_pass = 0;
    int n_total = 0;

    room_light_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rooms      (rooms),
        .lightson   (lightson),
        .countdown  (countdown),
        .active_cnt (active_cnt),
        .pending    (pending),
        .full       (full),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] rooms;
        logic [7:0] lit;
        logic [3:0] cnt;
        logic [1:0] st;
        int         room;
        logic [3:0] cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] rm,
                       input logic [7:0] lit, input logic [3:0] cnt, input logic [1:0] st,
                       input int room, input logic [3:0] cd);
        vec_t v;
        v.rst_n = r; v.en = e; v.rooms = rm; v.lit = lit; v.cnt = cnt;
        v.st = st; v.room = room; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Test 1: single room, 3 cycles occupied, then 10-edge hold and release.
        add(0, 1, 8'h01, 8'h00, 0, 0, 0, 0);
        repeat (3) add(1, 1, 8'h01, 8'h01, 1, 1, 0, 10);
        for (int t = 9; t >= 1; t--) add(1, 1, 8'h00, 8'h01, 1, 1, 0, 4'(t));
        add(1, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        // Test 4: room 3 re-requests at countdown 4, lamp never drops.
        add(0, 1, 8'h08, 8'h00, 0, 0, 3, 0);
        add(1, 1, 8'h08, 8'h08, 1, 1, 3, 10);
        for (int t = 9; t >= 4; t--) add(1, 1, 8'h00, 8'h08, 1, 1, 3, 4'(t));
        repeat (2) add(1, 1, 8'h08, 8'h08, 1, 1, 3, 10);
        // Test 5: pointer at 7, rooms 7 and 0 pending -> 7 then wrap to 0.
        add(0, 1, 8'h40, 8'h00, 0, 0, 6, 0);
        add(1, 1, 8'h40, 8'h40, 1, 1, 6, 10);
        add(1, 1, 8'hC1, 8'hC0, 2, 1, 7, 10);
        add(1, 1, 8'hC1, 8'hC1, 3, 1, 0, 10);
        add(1, 1, 8'hC1, 8'hC1, 3, 1, 0, 10);
        // enable=0: timers run, no grants, pointer frozen at 2.
        add(0, 1, 8'h02, 8'h00, 0, 0, 1, 0);
        add(1, 1, 8'h02, 8'h02, 1, 1, 1, 10);
        add(1, 0, 8'h06, 8'h02, 1, 1, 1, 10);
        add(1, 0, 8'h04, 8'h02, 1, 1, 1, 9);
        add(1, 1, 8'h04, 8'h06, 2, 1, 1, 8);

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            enable = vecs[i].en;
            rooms  = vecs[i].rooms;
            step();
            chk($sformatf("v%0d_lightson", i), 32'(lightson), 32'(vecs[i].lit));
            chk($sformatf("v%0d_active_cnt", i), 32'(active_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].st == 2'd2));
            chk($sformatf("v%0d_countdown", i), 32'(countdown[vecs[i].room*4 +: 4]),
                32'(vecs[i].cd));
        end

        // Test 2: all rooms request, five consecutive grants fill the slots.
        rst_n = 0; enable = 1; rooms = 8'hFF;
        step();
        rst_n = 1;
        step(); chk("t2_grant0", 32'(lightson), 32'h01);
        step(); chk("t2_grant1", 32'(lightson), 32'h03);
        step(); chk("t2_grant2", 32'(lightson), 32'h07);
        step(); chk("t2_grant3", 32'(lightson), 32'h0F);
        chk("t2_state_run", 32'(state), 32'd1);
        step(); chk("t2_grant4", 32'(lightson), 32'h1F);
        chk("t2_cnt", 32'(active_cnt), 32'd5);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_state", 32'(state), 32'd2);
        chk("t2_pending", 32'(pending), 32'hE0);
        step(); chk("t2_no_over_grant", 32'(lightson), 32'h1F);

        // Test 3: room 2 leaves; its slot returns 10 edges later and goes to room 5.
        rooms = 8'hFB;
        n = 0;
        while (lightson[2] && n < 20) begin
            step();
            n++;
            chk("t3_cnt_le_max", 32'(active_cnt <= 4'd5), 32'd1);
        end
        chk("t3_release_edges", 32'(n), 32'd10);
        chk("t3_after_release", 32'(lightson), 32'h1B);
        chk("t3_state_run", 32'(state), 32'd1);
        step();
        chk("t3_room5", 32'(lightson), 32'h3B);
        chk("t3_cnt", 32'(active_cnt), 32'd5);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_cd5", 32'(countdown[20 +: 4]), 32'd10);

        // Test 6: mid-operation reset, then enable=0 blocks grants.
        rst_n = 0; rooms = 8'h1F;
        step();
        rst_n = 1;
        repeat (5) step();
        chk("t6_lit5", 32'(lightson), 32'h1F);
        chk("t6_state_run", 32'(state), 32'd1);
        rst_n = 0;
        step();
        chk("t6_rst_lit", 32'(lightson), 32'h00);
        chk("t6_rst_cd", countdown, 32'h0);
        chk("t6_rst_cnt", 32'(active_cnt), 32'd0);
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_full", 32'(full), 32'd0);
        rst_n = 1; enable = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_grant", 32'(lightson), 32'h00);
        end
        chk("t6_pending", 32'(pending), 32'h1F);
        enable = 1;
        step();
        chk("t6_grant_after_enable", 32'(lightson), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
